// File: rtl/uiwave_mc_if.sv
// Link between the waveform compositor and the per-channel sample buffers:
// plot coordinates and trigger level out, per-channel hit flags back.
interface uiwave_mc_if #(
  parameter int unsigned N_CH = 2
);
  logic [11:0]     O_hcnt;
  logic [11:0]     O_vcnt;
  logic [7:0]      O_trig_level;
  logic [N_CH-1:0] I_ch_pix_en;

  modport master (
    output O_hcnt,
    output O_vcnt,
    output O_trig_level,
    input  I_ch_pix_en
  );

  modport slave (
    input  O_hcnt,
    input  O_vcnt,
    input  O_trig_level,
    output I_ch_pix_en
  );
endinterface

// File: rtl/uiwave_mc.sv
// Multi-channel oscilloscope pixel compositor: walks the plot area, asks the
// channel buffers for hits and overlays grid, trigger line and traces.
module uiwave_mc #(
  parameter int unsigned        N_CH      = 2,
  parameter int unsigned        H_ACT     = 750,
  parameter int unsigned        V_ROWS    = 256,
  parameter int unsigned        GRID_LOG2 = 6,
  parameter int unsigned        DOT_LOG2  = 3,
  parameter int unsigned        TRIG_INIT = 128,
  parameter logic [16*N_CH-1:0] CH_COLOR  = {16'h07E0, 16'hFFE0}
) (
  input  logic            I_vtc_clk,
  input  logic            I_vtc_rstn,
  input  logic            I_vtc_vs,
  input  logic            I_vtc_de,
  input  logic [N_CH-1:0] I_ch_en,
  input  logic            I_trig_up,
  input  logic            I_trig_dn,
  uiwave_mc_if.master     buf_if,
  output logic            O_vtc_vs,
  output logic            O_vtc_de,
  output logic [15:0]     O_vtc_rgb
);

  localparam int unsigned CW        = 12;
  localparam logic [CW-1:0] GRID_M  = CW'((1 << GRID_LOG2) - 1);
  localparam logic [CW-1:0] DOT_M   = CW'((1 << DOT_LOG2) - 1);
  localparam logic [CW-1:0] H_LAST  = CW'(H_ACT - 1);
  localparam logic [CW-1:0] H_END   = CW'(H_ACT);
  localparam logic [CW-1:0] V_END   = CW'(V_ROWS);
  localparam logic [CW-1:0] V_LAST  = 12'hFFF;
  localparam logic [7:0]    TRIG_RST = 8'(TRIG_INIT);
  localparam logic [15:0]   COL_TRIG = 16'hF81F;
  localparam logic [15:0]   COL_GRID = 16'h9492;

  // Timing pipeline: stage 0 (vs_r/de_r), stage 1, stage 2 (outputs)
  logic vs_r_q, de_r_q, vs_d1_q, de_d1_q, vs_d2_q, de_d2_q;

  logic [CW-1:0]   hcnt_q, hcnt_d;
  logic [CW-1:0]   vcnt_q, vcnt_d;
  logic [N_CH-1:0] mask_q, mask_d;
  logic [7:0]      pend_q, pend_d;
  logic [7:0]      trig_q, trig_d;
  logic            frame_ok_q, frame_ok_d;
  logic            pix_vld_q, pix_vld_d;
  logic            grid_q, grid_d;
  logic            trig_hit_q, trig_hit_d;
  logic [15:0]     rgb_q, rgb_d;

  logic            vs_rise_c, de_rise_c, de_fall_c;
  logic            in_reg_c, row_line_c, row_dot_c, col_line_c, col_dot_c;
  logic [N_CH-1:0] hit_c;
  logic            ch_hit_c;
  logic [15:0]     ch_col_c;

  // Counters advance on the same clock edge that moves vs_r/de_r, so the
  // counter value is already valid while de_r marks the pixel.
  always_comb begin
    vs_rise_c = I_vtc_vs & ~vs_r_q;
    de_rise_c = I_vtc_de & ~de_r_q;
    de_fall_c = de_r_q & ~I_vtc_de;

    hcnt_d = hcnt_q;
    if (de_rise_c) begin
      hcnt_d = '0;
    end else if (de_r_q && (hcnt_q != H_LAST)) begin
      hcnt_d = hcnt_q + CW'(1);
    end

    vcnt_d = vcnt_q;
    if (vs_rise_c) begin
      vcnt_d = '0;
    end else if (de_fall_c && (vcnt_q != V_LAST)) begin
      vcnt_d = vcnt_q + CW'(1);
    end

    mask_d     = vs_rise_c ? I_ch_en : mask_q;
    trig_d     = vs_rise_c ? pend_q  : trig_q;
    frame_ok_d = frame_ok_q | vs_rise_c;

    pend_d = pend_q;
    case ({I_trig_up, I_trig_dn})
      2'b10:   pend_d = pend_q + 8'd1;
      2'b01:   pend_d = pend_q - 8'd1;
      default: pend_d = pend_q;
    endcase
  end

  // Overlay flags, one cycle behind the counters to line up with buffer hits
  always_comb begin
    in_reg_c   = (hcnt_q < H_END) && (vcnt_q < V_END);
    row_line_c = ((vcnt_q & GRID_M) == GRID_M) || (vcnt_q == '0);
    row_dot_c  = (vcnt_q & DOT_M) == DOT_M;
    col_line_c = ((hcnt_q & GRID_M) == GRID_M) || (hcnt_q == '0);
    col_dot_c  = (hcnt_q & DOT_M) == DOT_M;

    pix_vld_d  = de_r_q && frame_ok_q && in_reg_c;
    grid_d     = (row_line_c && col_dot_c) || (col_line_c && row_dot_c) ||
                 ((hcnt_q == '0) && (vcnt_q == '0));
    trig_hit_d = (vcnt_q[7:0] == trig_q) && (hcnt_q[1:0] == 2'b11);
  end

  // Colour select: lowest enabled channel, then trigger, then grid
  always_comb begin
    hit_c    = buf_if.I_ch_pix_en & mask_q;
    ch_hit_c = 1'b0;
    ch_col_c = '0;
    for (int k = int'(N_CH) - 1; k >= 0; k--) begin
      if (hit_c[k]) begin
        ch_hit_c = 1'b1;
        ch_col_c = CH_COLOR[16*k +: 16];
      end
    end

    rgb_d = '0;
    if (pix_vld_q) begin
      if (ch_hit_c) begin
        rgb_d = ch_col_c;
      end else if (trig_hit_q) begin
        rgb_d = COL_TRIG;
      end else if (grid_q) begin
        rgb_d = COL_GRID;
      end
    end
  end

  always_ff @(posedge I_vtc_clk or negedge I_vtc_rstn) begin
    if (!I_vtc_rstn) begin
      vs_r_q     <= 1'b0;
      de_r_q     <= 1'b0;
      vs_d1_q    <= 1'b0;
      de_d1_q    <= 1'b0;
      vs_d2_q    <= 1'b0;
      de_d2_q    <= 1'b0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      mask_q     <= '0;
      pend_q     <= TRIG_RST;
      trig_q     <= TRIG_RST;
      frame_ok_q <= 1'b0;
      pix_vld_q  <= 1'b0;
      grid_q     <= 1'b0;
      trig_hit_q <= 1'b0;
      rgb_q      <= '0;
    end else begin
      vs_r_q     <= I_vtc_vs;
      de_r_q     <= I_vtc_de;
      vs_d1_q    <= vs_r_q;
      de_d1_q    <= de_r_q;
      vs_d2_q    <= vs_d1_q;
      de_d2_q    <= de_d1_q;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      trig_q     <= trig_d;
      frame_ok_q <= frame_ok_d;
      pix_vld_q  <= pix_vld_d;
      grid_q     <= grid_d;
      trig_hit_q <= trig_hit_d;
      rgb_q      <= rgb_d;
    end
  end

  assign O_vtc_vs            = vs_d2_q;
  assign O_vtc_de            = de_d2_q;
  assign O_vtc_rgb           = rgb_q;
  assign buf_if.O_hcnt       = hcnt_q;
  assign buf_if.O_vcnt       = vcnt_q;
  assign buf_if.O_trig_level = trig_q;

endmodule

// File: tb/tb_uiwave_mc.sv
// Directed bench for uiwave_mc: a pixel-level reference model queues the
// expected output of every driven cycle and the queue is drained 3 cycles later.
module tb_uiwave_mc;

  localparam int unsigned N_CH     = 2;
  localparam logic [15:0] CH0_COL  = 16'h07E0;
  localparam logic [15:0] CH1_COL  = 16'hFFE0;
  localparam logic [31:0] CH_COL   = {CH1_COL, CH0_COL};
  localparam int          LINE_ACT = 72;
  localparam int          LINE_BLK = 8;

  logic            clk = 1'b0;
  logic            I_vtc_rstn;
  logic            I_vtc_vs;
  logic            I_vtc_de;
  logic [N_CH-1:0] I_ch_en;
  logic            I_trig_up;
  logic            I_trig_dn;
  logic            O_vtc_vs;
  logic            O_vtc_de;
  logic [15:0]     O_vtc_rgb;

  always #5 clk = ~clk;

  uiwave_mc_if #(.N_CH(N_CH)) buf_if ();

  uiwave_mc #(
    .N_CH(N_CH), .H_ACT(750), .V_ROWS(256), .GRID_LOG2(6), .DOT_LOG2(3),
    .TRIG_INIT(128), .CH_COLOR(CH_COL)
  ) dut (
    .I_vtc_clk (clk),
    .I_vtc_rstn(I_vtc_rstn),
    .I_vtc_vs  (I_vtc_vs),
    .I_vtc_de  (I_vtc_de),
    .I_ch_en   (I_ch_en),
    .I_trig_up (I_trig_up),
    .I_trig_dn (I_trig_dn),
    .buf_if    (buf_if),
    .O_vtc_vs  (O_vtc_vs),
    .O_vtc_de  (O_vtc_de),
    .O_vtc_rgb (O_vtc_rgb)
  );

  typedef struct packed {
    logic        vs;
    logic        de;
    logic [15:0] rgb;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state as seen from the input side
  logic       m_vs_p, m_de_p, m_valid;
  logic [1:0] m_mask;
  logic [7:0] m_trig, m_pend;
  int         m_row, m_col;
  int         pix_mode;
  logic       g_up, g_dn;
  logic [1:0] ch_en;
  int         h_row[2];
  int         h_col[2];
  logic       h_de[2];

  function automatic logic [1:0] hit_fn(int row, int col);
    case (pix_mode)
      1:       return 2'b11;
      2:       return (row == 0 && col == 15) ? 2'b10 : 2'b00;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [15:0] exp_rgb(int row, int col, logic [1:0] hit);
    logic [1:0] h;
    logic       trig, grid;
    h = hit & m_mask;
    if (!m_valid || row >= 256 || col >= 750) return 16'h0000;
    if (h[0]) return CH0_COL;
    if (h[1]) return CH1_COL;
    trig = ((row % 256) == int'(m_trig)) && (col % 4 == 3);
    grid = (((row % 64 == 63) || row == 0) && (col % 8 == 7)) ||
           (((col % 64 == 63) || col == 0) && (row % 8 == 7)) ||
           (row == 0 && col == 0);
    if (trig) return 16'hF81F;
    if (grid) return 16'h9492;
    return 16'h0000;
  endfunction

  task automatic chk(string tag, logic [15:0] got, logic [15:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h row=%0d col=%0d", tag, got, want, m_row, m_col);
    end
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_vs"},   16'(O_vtc_vs),            16'h0);
    chk({tag, "_de"},   16'(O_vtc_de),            16'h0);
    chk({tag, "_rgb"},  O_vtc_rgb,                16'h0);
    chk({tag, "_hcnt"}, 16'(buf_if.O_hcnt),       16'h0);
    chk({tag, "_vcnt"}, 16'(buf_if.O_vcnt),       16'h0);
    chk({tag, "_trig"}, 16'(buf_if.O_trig_level), 16'd128);
  endtask

  // One pixel clock: drive, push expectation, clock, pop and compare
  task automatic step(logic vs, logic de);
    exp_t       e, o;
    logic [1:0] hit;
    I_vtc_vs  = vs;
    I_vtc_de  = de;
    I_trig_up = g_up;
    I_trig_dn = g_dn;
    I_ch_en   = ch_en;
    buf_if.I_ch_pix_en = h_de[1] ? hit_fn(h_row[1], h_col[1]) : 2'b00;
    if (vs && !m_vs_p) begin
      m_row   = 0;
      m_mask  = ch_en;
      m_trig  = m_pend;
      m_valid = 1'b1;
    end
    if (g_up && !g_dn)      m_pend = m_pend + 8'd1;
    else if (g_dn && !g_up) m_pend = m_pend - 8'd1;
    if (de && !m_de_p) m_col = 0;
    if (!de && m_de_p) m_row++;
    hit   = hit_fn(m_row, m_col);
    e.vs  = vs;
    e.de  = de;
    e.rgb = de ? exp_rgb(m_row, m_col, hit) : 16'h0000;
    sb.push_back(e);
    h_row[1] = h_row[0]; h_col[1] = h_col[0]; h_de[1] = h_de[0];
    h_row[0] = m_row;    h_col[0] = m_col;    h_de[0] = de;
    if (de) m_col++;
    m_vs_p = vs;
    m_de_p = de;
    g_up   = 1'b0;
    g_dn   = 1'b0;
    @(posedge clk);
    #1;
    o = sb.pop_front();
    chk("vs", 16'(O_vtc_vs), 16'(o.vs));
    chk("de", 16'(O_vtc_de), 16'(o.de));
    if (o.de) chk("rgb", O_vtc_rgb, o.rgb);
  endtask

  task automatic do_reset(int ncyc);
    I_vtc_rstn = 1'b0;
    #2;
    chk_reset("rst_now");
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      chk_reset("rst_hold");
    end
    I_vtc_rstn = 1'b1;
    m_vs_p  = 1'b0;
    m_de_p  = 1'b0;
    m_valid = 1'b0;
    m_mask  = 2'b00;
    m_trig  = 8'd128;
    m_pend  = 8'd128;
    h_de[0] = 1'b0;
    h_de[1] = 1'b0;
    sb.delete();
    sb.push_back('0);
    sb.push_back('0);
  endtask

  task automatic frame_head();
    repeat (4) step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);
  endtask

  task automatic lines(int n);
    repeat (n) begin
      repeat (LINE_ACT) step(1'b0, 1'b1);
      repeat (LINE_BLK) step(1'b0, 1'b0);
    end
  endtask

  initial begin
    I_vtc_rstn = 1'b0;
    I_vtc_vs   = 1'b0;
    I_vtc_de   = 1'b0;
    I_ch_en    = '0;
    I_trig_up  = 1'b0;
    I_trig_dn  = 1'b0;
    buf_if.I_ch_pix_en = '0;
    g_up = 1'b0; g_dn = 1'b0; ch_en = 2'b00; pix_mode = 0;
    m_row = 0; m_col = 0;
    h_row[0] = 0; h_row[1] = 0; h_col[0] = 0; h_col[1] = 0;

    @(posedge clk);
    #1;
    do_reset(3);

    // 130 raise pulses: pending wraps to 2, committed level untouched
    repeat (130) begin
      g_up = 1'b1;
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
    end
    chk("trig_before_vs", 16'(buf_if.O_trig_level), 16'd128);

    // Frame A: grid only, tall enough to leave the plot rows; trigger on row 2
    ch_en = 2'b11;
    frame_head();
    chk("trig_commit_2", 16'(buf_if.O_trig_level), 16'd2);
    lines(262);

    // Frame B: both channels hit; mask change mid-frame is deferred
    pix_mode = 1;
    frame_head();
    lines(4);
    ch_en = 2'b10;
    lines(4);
    g_up = 1'b1;
    g_dn = 1'b1;
    step(1'b0, 1'b0);

    // Frame C: channel 1 only; two lower pulses take pending to 0
    frame_head();
    chk("trig_after_both", 16'(buf_if.O_trig_level), 16'd2);
    lines(4);
    g_dn = 1'b1;
    step(1'b0, 1'b0);
    g_dn = 1'b1;
    step(1'b0, 1'b0);
    lines(4);

    // Frame D: trigger on grid row 0, single hit at (0,15); lower pulse at frame start
    ch_en    = 2'b11;
    pix_mode = 2;
    g_dn     = 1'b1;
    frame_head();
    chk("trig_commit_0", 16'(buf_if.O_trig_level), 16'd0);
    lines(8);

    // Frame E: level wrapped to 255, then reset in the middle of a line
    pix_mode = 0;
    frame_head();
    chk("trig_commit_255", 16'(buf_if.O_trig_level), 16'd255);
    lines(3);
    repeat (30) step(1'b0, 1'b1);
    do_reset(2);
    chk("trig_after_rst", 16'(buf_if.O_trig_level), 16'd128);
    repeat (42) step(1'b0, 1'b1);
    repeat (LINE_BLK) step(1'b0, 1'b0);
    lines(3);

    // Frame F: picture returns after the next frame start
    frame_head();
    lines(9);
    repeat (4) step(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
